uart_tx_fifo: RTL and testbench

//  Serialises bytes onto an asynchronous UART line, LSB first: start, data, optional parity, stop.

---
 rtl/uart_tx_fifo_pkg.sv | 18 +
 rtl/uart_tx_fifo_byte_fifo.sv | 48 ++++
 rtl/uart_tx_fifo.sv | 148 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART definitions: frame constants and the transmitter state encoding.
package uart_tx_fifo_pkg;

  localparam int UART_CLK_FREQ     = 50_000_000;
  localparam int UART_BAUD_RATE    = 115_200;
  localparam int UART_DATA_LENGTH  = 8;
  localparam bit UART_PARITY_CHECK = 1'b0;
  localparam bit UART_PARITY_MODE  = 1'b0;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_states_t;

endpackage

// File: rtl/uart_tx_fifo_byte_fifo.sv
// First-word-fall-through byte buffer feeding the UART transmitter.
module uart_byte_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = UART_DATA_LENGTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int LB = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [LB:0]      wr_ptr;
  logic [LB:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full    = (wr_ptr[LB] != rd_ptr[LB]) && (wr_ptr[LB-1:0] == rd_ptr[LB-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr[LB-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr[LB-1:0]] <= wr_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with input byte FIFO; frames leave back-to-back while bytes are queued.
//   state     | meaning
//   TX_IDLE   | line high, waiting for a buffered byte
//   TX_START  | start bit (line low)
//   TX_DATA   | data bits, LSB first
//   TX_PARITY | optional parity bit
//   TX_STOP   | stop bit(s), line high
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int PULSE_WIDTH    = UART_CLK_FREQ / UART_BAUD_RATE,
  parameter int LB_PULSE_WIDTH = $clog2(PULSE_WIDTH),
  parameter int FIFO_DEPTH     = 4,
  parameter int STOP_BITS      = 1,
  parameter bit PARITY_CHECK   = UART_PARITY_CHECK,
  parameter bit PARITY_MODE    = UART_PARITY_MODE
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [UART_DATA_LENGTH-1:0] i_data,
  input  logic                        i_valid,
  output logic                        o_ready,
  output logic                        o_serial_out,
  output logic                        o_busy,
  output logic                        o_done
);

  localparam int BIT_CNT_W = $clog2(UART_DATA_LENGTH) + 1;
  localparam logic [LB_PULSE_WIDTH:0] BAUD_RELOAD = (LB_PULSE_WIDTH+1)'(PULSE_WIDTH - 1);
  localparam logic [LB_PULSE_WIDTH:0] BAUD_ONE    = (LB_PULSE_WIDTH+1)'(1);

  tx_states_t                  state_q, state_d;
  logic [LB_PULSE_WIDTH:0]     baud_q;
  logic [BIT_CNT_W-1:0]        bit_cnt_q;
  logic [UART_DATA_LENGTH-1:0] shift_q;
  logic [UART_DATA_LENGTH-1:0] fifo_data;
  logic                        parity_q;
  logic                        line_q, line_d;
  logic                        done_q, done_d;
  logic                        pop, tick, last_data, last_stop;
  logic                        fifo_full, fifo_empty;

  uart_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_LENGTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (i_valid),
    .wr_data (i_data),
    .rd_en   (pop),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign tick      = (baud_q == '0);
  assign last_data = (bit_cnt_q == BIT_CNT_W'(UART_DATA_LENGTH - 1));
  assign last_stop = (bit_cnt_q == BIT_CNT_W'(STOP_BITS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= TX_IDLE;
      baud_q    <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      line_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      done_q  <= done_d;
      if (pop) begin
        shift_q  <= fifo_data;
        parity_q <= PARITY_MODE ^ (^fifo_data);
      end else if (state_q == TX_DATA && tick && state_d == TX_DATA) begin
        shift_q <= shift_q >> 1;
      end
      if (state_d != TX_IDLE && (pop || tick)) begin
        baud_q <= BAUD_RELOAD;
      end else if (!tick) begin
        baud_q <= baud_q - 1'b1;
      end
      if (state_d != state_q) begin
        bit_cnt_q <= '0;
      end else if (tick && state_q != TX_IDLE) begin
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          state_d = TX_START;
          pop     = 1'b1;
        end
      end
      TX_START:  if (tick) state_d = TX_DATA;
      TX_DATA:   if (tick && last_data) state_d = PARITY_CHECK ? TX_PARITY : TX_STOP;
      TX_PARITY: if (tick) state_d = TX_STOP;
      TX_STOP: begin
        if (tick && last_stop) begin
          if (!fifo_empty) begin
            state_d = TX_START;
            pop     = 1'b1;
          end else begin
            state_d = TX_IDLE;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // line_d/done_d are the next register values, so the line never glitches.
  always_comb begin
    line_d = line_q;
    done_d = 1'b0;
    case (state_q)
      TX_IDLE:  line_d = !pop;
      TX_START: if (tick) line_d = shift_q[0];
      TX_DATA: begin
        if (tick) begin
          if (state_d == TX_DATA)        line_d = shift_q[1];
          else if (state_d == TX_PARITY) line_d = parity_q;
          else                           line_d = 1'b1;
        end
      end
      TX_PARITY: if (tick) line_d = 1'b1;
      TX_STOP: begin
        done_d = last_stop && (baud_q == BAUD_ONE);
        if (tick && last_stop) line_d = !pop;
      end
      default: line_d = 1'b1;
    endcase
  end

  assign o_ready      = !fifo_full;
  assign o_serial_out = line_q;
  assign o_busy       = (state_q != TX_IDLE) || !fifo_empty;
  assign o_done       = done_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: three instances cover no-parity, even parity and odd parity with two stop bits.
module tb_uart_tx_fifo;
  import uart_tx_fifo_pkg::*;

  localparam int PW = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] da = '0, db = '0, dc = '0;
  logic va = 1'b0, vb = 1'b0, vc = 1'b0;
  logic ready_a, ser_a, busy_a, done_a;
  logic ready_b, ser_b, busy_b, done_b;
  logic ready_c, ser_c, busy_c, done_c;

  int cmp_count = 0;
  int fail_count = 0;
  int cyc = 0;
  int rx_count = 0;
  bit mon_en = 1'b0;
  logic [7:0] sb_a[$];
  int starts_a[$];

  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo #(.PULSE_WIDTH(PW), .FIFO_DEPTH(4), .STOP_BITS(1), .PARITY_CHECK(1'b0), .PARITY_MODE(1'b0)) dut_a (
    .clk(clk), .reset(reset), .i_data(da), .i_valid(va), .o_ready(ready_a),
    .o_serial_out(ser_a), .o_busy(busy_a), .o_done(done_a));
  uart_tx_fifo #(.PULSE_WIDTH(PW), .FIFO_DEPTH(4), .STOP_BITS(1), .PARITY_CHECK(1'b1), .PARITY_MODE(1'b0)) dut_b (
    .clk(clk), .reset(reset), .i_data(db), .i_valid(vb), .o_ready(ready_b),
    .o_serial_out(ser_b), .o_busy(busy_b), .o_done(done_b));
  uart_tx_fifo #(.PULSE_WIDTH(PW), .FIFO_DEPTH(4), .STOP_BITS(2), .PARITY_CHECK(1'b1), .PARITY_MODE(1'b1)) dut_c (
    .clk(clk), .reset(reset), .i_data(dc), .i_valid(vc), .o_ready(ready_c),
    .o_serial_out(ser_c), .o_busy(busy_c), .o_done(done_c));

  function automatic logic ser_of(input int w);
    case (w) 0: return ser_a; 1: return ser_b; default: return ser_c; endcase
  endfunction
  function automatic logic done_of(input int w);
    case (w) 0: return done_a; 1: return done_b; default: return done_c; endcase
  endfunction
  function automatic logic ready_of(input int w);
    case (w) 0: return ready_a; 1: return ready_b; default: return ready_c; endcase
  endfunction
  function automatic logic busy_of(input int w);
    case (w) 0: return busy_a; 1: return busy_b; default: return busy_c; endcase
  endfunction

  task automatic drive(input int w, input logic [7:0] b, input logic v);
    case (w)
      0: begin da = b; va = v; end
      1: begin db = b; vb = v; end
      default: begin dc = b; vc = v; end
    endcase
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input int w, input logic [7:0] b, input bit track, output int waited);
    int t;
    t = 0;
    drive(w, b, 1'b1);
    while (ready_of(w) !== 1'b1 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    waited = t;
    if (ready_of(w) !== 1'b1) begin
      cmp_count++; fail_count++;
      $display("FAIL send_timeout dut%0d: o_ready=%b, required 1", w, ready_of(w));
    end else if (track && w == 0) begin
      sb_a.push_back(b);
    end
    @(negedge clk);
    drive(w, b, 1'b0);
  endtask

  task automatic wait_idle(input int w);
    int t;
    t = 0;
    while (busy_of(w) !== 1'b0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    if (busy_of(w) !== 1'b0) begin
      cmp_count++; fail_count++;
      $display("FAIL idle_timeout dut%0d: o_busy=%b, required 0", w, busy_of(w));
    end
  endtask

  // Cycle 0 of the capture is the first low cycle of the start bit.
  task automatic capture(input int w, input int len, output logic [399:0] lv,
                         output logic [399:0] dv, output int lead);
    int t;
    t = 0;
    lv = '1;
    dv = '0;
    while (ser_of(w) !== 1'b0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    lead = t;
    if (ser_of(w) !== 1'b0) begin
      cmp_count++; fail_count++;
      $display("FAIL start_timeout dut%0d: line=%b, required 0", w, ser_of(w));
    end
    for (int k = 0; k < len; k++) begin
      lv[k] = ser_of(w);
      dv[k] = done_of(w);
      @(negedge clk);
    end
  endtask

  task automatic add_frame(inout logic [399:0] lv, inout logic [399:0] dv, inout int pos,
                           input logic [7:0] b, input bit par_en, input logic par_val, input int stops);
    logic fb [12];
    int n;
    n = 0;
    fb[n] = 1'b0; n++;
    for (int i = 0; i < 8; i++) begin fb[n] = b[i]; n++; end
    if (par_en) begin fb[n] = par_val; n++; end
    for (int i = 0; i < stops; i++) begin fb[n] = 1'b1; n++; end
    for (int j = 0; j < n; j++)
      for (int k = 0; k < PW; k++) begin
        lv[pos] = fb[j];
        pos++;
      end
    dv[pos-1] = 1'b1;
  endtask

  // Receiver model for dut_a: mid-bit sampling, compared against the scoreboard.
  initial begin
    logic [7:0] rx;
    logic start_ok, stop_bit;
    logic [7:0] exp_b;
    forever begin
      @(negedge clk);
      if (mon_en && !reset && ser_a === 1'b0) begin
        starts_a.push_back(cyc);
        repeat (PW/2) @(negedge clk);
        start_ok = (ser_a === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (PW) @(negedge clk);
          rx[i] = ser_a;
        end
        repeat (PW) @(negedge clk);
        stop_bit = ser_a;
        cmp_count++;
        if (sb_a.size() == 0) begin
          fail_count++;
          $display("FAIL rx_unexpected: got byte %02h, required no frame", rx);
        end else begin
          exp_b = sb_a.pop_front();
          if (rx !== exp_b || !start_ok || stop_bit !== 1'b1) begin
            fail_count++;
            $display("FAIL rx_byte: got %02h start_ok=%b stop=%b, required %02h start_ok=1 stop=1",
                     rx, start_ok, stop_bit, exp_b);
          end
        end
        rx_count++;
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    cmp_count++;
    if ({ser_a, ready_a, busy_a, done_a} !== 4'b1100) begin
      fail_count++;
      $display("FAIL reset_a: line/ready/busy/done=%b, required 1100", {ser_a, ready_a, busy_a, done_a});
    end
    cmp_count++;
    if ({ser_b, ready_b, busy_b, done_b, ser_c, ready_c, busy_c, done_c} !== 8'b11001100) begin
      fail_count++;
      $display("FAIL reset_bc: %b, required 11001100",
               {ser_b, ready_b, busy_b, done_b, ser_c, ready_c, busy_c, done_c});
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
  endtask

  task automatic test_single_frame();
    logic [399:0] lv, dv, el, ed;
    int pos, w, lead;
    el = '1; ed = '0; pos = 0;
    add_frame(el, ed, pos, 8'h55, 1'b0, 1'b0, 1);
    send(0, 8'h55, 1'b1, w);
    cmp_count++;
    if (ser_a !== 1'b1 || busy_a !== 1'b1) begin
      fail_count++;
      $display("FAIL first_edge: line=%b busy=%b, required line=1 busy=1", ser_a, busy_a);
    end
    capture(0, 170, lv, dv, lead);
    cmp_count++;
    if (lead !== 1) begin
      fail_count++;
      $display("FAIL start_latency: %0d cycles, required 1", lead);
    end
    cmp_count++;
    if (lv !== el) begin
      fail_count++;
      $display("FAIL frame_55_line: got %h, required %h", lv[169:0], el[169:0]);
    end
    cmp_count++;
    if (dv !== ed) begin
      fail_count++;
      $display("FAIL frame_55_done: got %h, required %h", dv[169:0], ed[169:0]);
    end
    wait_idle(0);
  endtask

  task automatic test_parity();
    logic [399:0] lv, dv, el, ed;
    int pos, w, lead;
    el = '1; ed = '0; pos = 0;
    add_frame(el, ed, pos, 8'h07, 1'b1, 1'b1, 1);
    send(1, 8'h07, 1'b0, w);
    capture(1, 185, lv, dv, lead);
    cmp_count++;
    if (lv !== el || dv !== ed) begin
      fail_count++;
      $display("FAIL parity_even: line=%h done=%h, required line=%h done=%h",
               lv[184:0], dv[184:0], el[184:0], ed[184:0]);
    end
    el = '1; ed = '0; pos = 0;
    add_frame(el, ed, pos, 8'h07, 1'b1, 1'b0, 2);
    send(2, 8'h07, 1'b0, w);
    capture(2, 200, lv, dv, lead);
    cmp_count++;
    if (lv !== el || dv !== ed) begin
      fail_count++;
      $display("FAIL parity_odd: line=%h done=%h, required line=%h done=%h",
               lv[199:0], dv[199:0], el[199:0], ed[199:0]);
    end
    wait_idle(1);
    wait_idle(2);
  endtask

  task automatic test_back_to_back();
    int waits [6];
    int base, t, bad_gap, stall_early;
    wait_idle(0);
    starts_a.delete();
    base = rx_count;
    for (int i = 0; i < 6; i++) send(0, 8'hA1 + 8'(i), 1'b1, waits[i]);
    stall_early = 0;
    for (int i = 0; i < 5; i++) stall_early += waits[i];
    cmp_count++;
    if (stall_early !== 0) begin
      fail_count++;
      $display("FAIL fill_no_stall: stall cycles=%0d, required 0", stall_early);
    end
    cmp_count++;
    if (waits[5] !== 157) begin
      fail_count++;
      $display("FAIL ready_recover: A6 stalled %0d cycles, required 157", waits[5]);
    end
    t = 0;
    while (rx_count < base + 6 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    cmp_count++;
    if (starts_a.size() !== 6) begin
      fail_count++;
      $display("FAIL burst_frames: %0d frames, required 6", starts_a.size());
    end else begin
      bad_gap = 0;
      for (int i = 1; i < 6; i++) if (starts_a[i] - starts_a[i-1] != 160) bad_gap++;
      cmp_count++;
      if (bad_gap !== 0) begin
        fail_count++;
        $display("FAIL burst_contiguous: %0d gaps not 160 clk, required 0", bad_gap);
      end
    end
    wait_idle(0);
  endtask

  task automatic test_two_stop();
    logic [399:0] lv, dv, el, ed;
    int pos, w, lead, run;
    el = '1; ed = '0; pos = 0;
    add_frame(el, ed, pos, 8'h38, 1'b1, 1'b1 ^ (^8'h38), 2);
    add_frame(el, ed, pos, 8'h81, 1'b1, 1'b1 ^ (^8'h81), 2);
    send(2, 8'h38, 1'b0, w);
    send(2, 8'h81, 1'b0, w);
    capture(2, 390, lv, dv, lead);
    run = 0;
    for (int k = 191; k >= 0 && lv[k] === 1'b1; k--) run++;
    cmp_count++;
    if (run !== 32 || lv[192] !== 1'b0) begin
      fail_count++;
      $display("FAIL stop2_gap: %0d high clk then %b, required 32 then 0", run, lv[192]);
    end
    cmp_count++;
    if (lv !== el || dv !== ed) begin
      fail_count++;
      $display("FAIL stop2_frames: line=%h done=%h, required line=%h done=%h",
               lv[389:0], dv[389:0], el[389:0], ed[389:0]);
    end
    wait_idle(2);
  endtask

  task automatic test_reset_midframe();
    logic [399:0] lv, dv;
    int w, lead, bad;
    wait_idle(0);
    mon_en = 1'b0;
    send(0, 8'hC3, 1'b0, w);
    send(0, 8'h11, 1'b0, w);
    send(0, 8'h22, 1'b0, w);
    capture(0, 16 + 3*PW + 4, lv, dv, lead);
    reset = 1'b1;
    @(negedge clk);
    cmp_count++;
    if ({ser_a, busy_a, ready_a} !== 3'b101) begin
      fail_count++;
      $display("FAIL reset_midframe: line/busy/ready=%b, required 101", {ser_a, busy_a, ready_a});
    end
    reset = 1'b0;
    bad = 0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (ser_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) bad++;
    end
    cmp_count++;
    if (bad !== 0) begin
      fail_count++;
      $display("FAIL after_reset_quiet: %0d active cycles, required 0", bad);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_random_loopback();
    int base, w, t;
    logic [7:0] b;
    base = rx_count;
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom);
      send(0, b, 1'b1, w);
      if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 200)) @(negedge clk);
    end
    t = 0;
    while (rx_count < base + 256 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    cmp_count++;
    if (rx_count - base !== 256 || sb_a.size() !== 0) begin
      fail_count++;
      $display("FAIL loopback_count: received %0d with %0d pending, required 256 with 0",
               rx_count - base, sb_a.size());
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_parity();
    test_back_to_back();
    test_two_stop();
    test_reset_midframe();
    test_random_loopback();
    $display("End of test - %0d assertions evaluated, %0d failures", cmp_count, fail_count);
    $finish;
  end

endmodule
